// File: rtl/riscv_test_monitor_pkg.sv
// Shared types for the riscv-tests pass/fail/timeout monitor.
// Holds the verdict state encoding and the event-source mode selectors.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int MODE_PC     = 0;
  localparam int MODE_TOHOST = 1;
  localparam int MODE_BOTH   = 2;

endpackage

// File: rtl/riscv_test_monitor_hold_counter.sv
// Counts consecutive retirements at the pass-loop PC and flags the retirement
// that completes a run of HOLD matches.
module tm_hold_counter #(
  parameter int               XLEN    = 32,
  parameter logic [XLEN-1:0]  PASS_PC = 32'h44,
  parameter int               HOLD    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic            retire_valid_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            hold_hit_o
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  logic [CW-1:0] cnt_q;
  logic          match;

  assign match = retire_valid_i && (pc_i == PASS_PC);

  // The HOLD-th match is reported in the same cycle it is presented, so the
  // verdict lands on the edge that samples it.
  assign hold_hit_o = enable_i && match && (cnt_q == HOLD_LAST);

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && retire_valid_i) begin
      if (!match || hold_hit_o) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout detector for riscv-tests runs: watches the pass-loop PC
// with gp and/or tohost writes, and reports a sticky verdict and cycle count.
module riscv_test_monitor
  import test_monitor_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PASS_PC     = 32'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
  parameter int              MODE        = MODE_BOTH,
  parameter int              HOLD        = 2,
  parameter int              TIMEOUT     = 5000,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  gp_i,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic [XLEN-1:0]  fail_num,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0]  PASS_CODE    = XLEN'(1);

  state_e           state_q;
  logic             done_q, passed_q, failed_q, timed_out_q;
  logic [XLEN-1:0]  fail_num_q;
  logic [CNT_W-1:0] cycles_q;

  logic in_run;
  logic hold_hit;
  logic th_hit, pc_hit, to_hit;

  assign in_run = (state_q == ST_RUN);

  tm_hold_counter #(
    .XLEN    (XLEN),
    .PASS_PC (PASS_PC),
    .HOLD    (HOLD)
  ) u_hold (
    .clk            (clk),
    .rst_n          (rst),
    .clear_i        (clear),
    .enable_i       (in_run && (MODE != MODE_TOHOST)),
    .retire_valid_i (retire_valid),
    .pc_i           (pc_i),
    .hold_hit_o     (hold_hit)
  );

  // Only writes with bit 0 set carry a verdict; others are progress markers.
  assign th_hit = (MODE != MODE_PC) && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign pc_hit = (MODE != MODE_TOHOST) && hold_hit;
  assign to_hit = (cycles_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      done_q      <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timed_out_q <= 1'b0;
      fail_num_q  <= '0;
      cycles_q    <= '0;
    end else if (clear) begin
      state_q     <= ST_RUN;
      done_q      <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timed_out_q <= 1'b0;
      fail_num_q  <= '0;
      cycles_q    <= '0;
    end else if (in_run) begin
      // Verdict edges do not advance cycles: the count freezes at its last RUN value.
      if (th_hit) begin
        done_q <= 1'b1;
        if (mem_wdata == PASS_CODE) begin
          state_q  <= ST_PASS;
          passed_q <= 1'b1;
        end else begin
          state_q    <= ST_FAIL;
          failed_q   <= 1'b1;
          fail_num_q <= mem_wdata >> 1;
        end
      end else if (pc_hit) begin
        done_q <= 1'b1;
        if (gp_i == PASS_CODE) begin
          state_q  <= ST_PASS;
          passed_q <= 1'b1;
        end else begin
          state_q    <= ST_FAIL;
          failed_q   <= 1'b1;
          fail_num_q <= gp_i >> 1;
        end
      end else if (to_hit) begin
        state_q     <= ST_TIMEOUT;
        done_q      <= 1'b1;
        timed_out_q <= 1'b1;
      end else if (cycles_q != '1) begin
        cycles_q <= cycles_q + 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign passed    = passed_q;
  assign failed    = failed_q;
  assign timed_out = timed_out_q;
  assign fail_num  = fail_num_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: three instances (PC-only, tohost-only,
// both) share one stimulus bus and are compared against hand-computed verdicts.
module tb_riscv_test_monitor;
  import test_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        retire_valid;
  logic [31:0] pc_i, gp_i;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;

  logic        pc_done, pc_pass, pc_fail, pc_to;
  logic [31:0] pc_fn, pc_cyc;
  logic        th_done, th_pass, th_fail, th_to;
  logic [31:0] th_fn, th_cyc;
  logic        bo_done, bo_pass, bo_fail, bo_to;
  logic [31:0] bo_fn, bo_cyc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_test_monitor #(.MODE(MODE_PC), .HOLD(2), .TIMEOUT(5000)) u_pc (
    .clk(clk), .rst(rst), .clear(clear), .retire_valid(retire_valid),
    .pc_i(pc_i), .gp_i(gp_i), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(pc_done), .passed(pc_pass), .failed(pc_fail), .timed_out(pc_to),
    .fail_num(pc_fn), .cycles(pc_cyc)
  );

  riscv_test_monitor #(.MODE(MODE_TOHOST), .HOLD(2), .TIMEOUT(30)) u_th (
    .clk(clk), .rst(rst), .clear(clear), .retire_valid(retire_valid),
    .pc_i(pc_i), .gp_i(gp_i), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(th_done), .passed(th_pass), .failed(th_fail), .timed_out(th_to),
    .fail_num(th_fn), .cycles(th_cyc)
  );

  riscv_test_monitor #(.MODE(MODE_BOTH), .HOLD(2), .TIMEOUT(20)) u_both (
    .clk(clk), .rst(rst), .clear(clear), .retire_valid(retire_valid),
    .pc_i(pc_i), .gp_i(gp_i), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(bo_done), .passed(bo_pass), .failed(bo_fail), .timed_out(bo_to),
    .fail_num(bo_fn), .cycles(bo_cyc)
  );

  typedef struct {
    logic        clr, rv;
    logic [31:0] pc, gp;
    logic        we;
    logic [31:0] addr, wd;
    state_e      st_pc;   logic [31:0] fn_pc; logic [31:0] cyc_pc;
    state_e      st_th;   logic [31:0] fn_th;
    state_e      st_both; logic [31:0] fn_both;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic rv, logic [31:0] pc, logic [31:0] gp,
                              logic we, logic [31:0] addr, logic [31:0] wd,
                              state_e sp, logic [31:0] fp, logic [31:0] cp,
                              state_e st, logic [31:0] ft,
                              state_e sb, logic [31:0] fb);
    vec_t v;
    v.clr = clr; v.rv = rv; v.pc = pc; v.gp = gp; v.we = we; v.addr = addr; v.wd = wd;
    v.st_pc = sp; v.fn_pc = fp; v.cyc_pc = cp;
    v.st_th = st; v.fn_th = ft;
    v.st_both = sb; v.fn_both = fb;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(string name, logic d, logic p, logic f, logic t,
                           logic [31:0] fn, state_e st, logic [31:0] efn);
    logic [3:0] ef;
    case (st)
      ST_PASS:    ef = 4'b1100;
      ST_FAIL:    ef = 4'b1010;
      ST_TIMEOUT: ef = 4'b1001;
      default:    ef = 4'b0000;
    endcase
    check({name, ".done_pass_fail_to"}, {60'd0, d, p, f, t}, {60'd0, ef});
    check({name, ".fail_num"}, {32'd0, fn}, {32'd0, efn});
  endtask

  task automatic drive(logic clr, logic rv, logic [31:0] pc, logic [31:0] gp,
                       logic we, logic [31:0] addr, logic [31:0] wd);
    clear = clr; retire_valid = rv; pc_i = pc; gp_i = gp;
    mem_we = we; mem_addr = addr; mem_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Table of single-cycle vectors; each row is checked after the edge that samples it.
    vecs.push_back(mk(1,0,32'h00,0, 0,32'h0000,0,     ST_RUN,0,0,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h40,1, 0,32'h0000,0,     ST_RUN,0,1,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,1, 0,32'h0000,0,     ST_RUN,0,2,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,1, 0,32'h0000,0,     ST_PASS,0,2, ST_RUN,0,  ST_PASS,0));
    vecs.push_back(mk(0,0,32'h00,0, 0,32'h0000,0,     ST_PASS,0,2, ST_RUN,0,  ST_PASS,0));
    vecs.push_back(mk(1,0,32'h00,0, 0,32'h0000,0,     ST_RUN,0,0,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,7, 0,32'h0000,0,     ST_RUN,0,1,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h48,7, 0,32'h0000,0,     ST_RUN,0,2,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,7, 0,32'h0000,0,     ST_RUN,0,3,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,0,32'h00,7, 0,32'h0000,0,     ST_RUN,0,4,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,7, 0,32'h0000,0,     ST_FAIL,3,4, ST_RUN,0,  ST_FAIL,3));
    vecs.push_back(mk(1,0,32'h00,0, 0,32'h0000,0,     ST_RUN,0,0,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,0,32'h00,0, 1,32'h1000,32'h2, ST_RUN,0,1,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,0,32'h00,0, 1,32'h1004,32'h1, ST_RUN,0,2,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,0,32'h00,0, 1,32'h1000,32'hB, ST_RUN,0,3,  ST_FAIL,5, ST_FAIL,5));
    vecs.push_back(mk(0,1,32'h44,1, 0,32'h0000,0,     ST_RUN,0,4,  ST_FAIL,5, ST_FAIL,5));
    vecs.push_back(mk(1,0,32'h00,0, 0,32'h0000,0,     ST_RUN,0,0,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,9, 0,32'h0000,0,     ST_RUN,0,1,  ST_RUN,0,  ST_RUN,0));
    vecs.push_back(mk(0,1,32'h44,9, 1,32'h1000,32'h1, ST_FAIL,4,1, ST_PASS,0, ST_PASS,0));

    #12;
    check_dut("reset.pc", pc_done, pc_pass, pc_fail, pc_to, pc_fn, ST_RUN, 0);
    check("reset.pc.cycles", {32'd0, pc_cyc}, 64'd0);
    check_dut("reset.both", bo_done, bo_pass, bo_fail, bo_to, bo_fn, ST_RUN, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].rv, vecs[i].pc, vecs[i].gp,
            vecs[i].we, vecs[i].addr, vecs[i].wd);
      step();
      check_dut($sformatf("vec%0d.pc", i), pc_done, pc_pass, pc_fail, pc_to, pc_fn,
                vecs[i].st_pc, vecs[i].fn_pc);
      check($sformatf("vec%0d.pc.cycles", i), {32'd0, pc_cyc}, {32'd0, vecs[i].cyc_pc});
      check_dut($sformatf("vec%0d.th", i), th_done, th_pass, th_fail, th_to, th_fn,
                vecs[i].st_th, vecs[i].fn_th);
      check_dut($sformatf("vec%0d.both", i), bo_done, bo_pass, bo_fail, bo_to, bo_fn,
                vecs[i].st_both, vecs[i].fn_both);
    end

    // Timeout boundary: u_both (TIMEOUT=20) expires on the 20th edge after clear.
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 19) begin
        check_dut("to.k19.both", bo_done, bo_pass, bo_fail, bo_to, bo_fn, ST_RUN, 0);
        check("to.k19.both.cycles", {32'd0, bo_cyc}, 64'd19);
      end
    end
    check_dut("to.k20.both", bo_done, bo_pass, bo_fail, bo_to, bo_fn, ST_TIMEOUT, 0);
    check("to.k20.both.cycles", {32'd0, bo_cyc}, 64'd19);
    check_dut("to.k20.th", th_done, th_pass, th_fail, th_to, th_fn, ST_RUN, 0);
    drive(0, 0, 0, 0, 1, 32'h1000, 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_dut("to.late.both", bo_done, bo_pass, bo_fail, bo_to, bo_fn, ST_TIMEOUT, 0);
    check("to.late.both.cycles", {32'd0, bo_cyc}, 64'd19);
    check_dut("to.late.th", th_done, th_pass, th_fail, th_to, th_fn, ST_PASS, 0);
    check("to.late.th.cycles", {32'd0, th_cyc}, 64'd20);
    check("to.late.pc.cycles", {32'd0, pc_cyc}, 64'd21);
    step();
    check("to.frozen.th.cycles", {32'd0, th_cyc}, 64'd20);

    // Async reset mid-run with u_th holding a PASS verdict.
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 32'h1000, 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step();
    check("rst.pre.pc.cycles", {32'd0, pc_cyc}, 64'd7);
    check_dut("rst.pre.th", th_done, th_pass, th_fail, th_to, th_fn, ST_PASS, 0);
    #2 rst = 1'b0;
    #1;
    check("rst.async.pc.cycles", {32'd0, pc_cyc}, 64'd0);
    check_dut("rst.async.th", th_done, th_pass, th_fail, th_to, th_fn, ST_RUN, 0);
    check("rst.async.both.cycles", {32'd0, bo_cyc}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rst.restart.pc.cycles", {32'd0, pc_cyc}, 64'd1);
    step();
    check("rst.restart2.pc.cycles", {32'd0, pc_cyc}, 64'd2);

    // Clear after a PASS re-arms the monitor and zeroes the count.
    drive(0, 0, 0, 0, 1, 32'h1000, 32'h1);
    step();
    check_dut("clr.pre.th", th_done, th_pass, th_fail, th_to, th_fn, ST_PASS, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_dut("clr.post.th", th_done, th_pass, th_fail, th_to, th_fn, ST_RUN, 0);
    check("clr.post.th.cycles", {32'd0, th_cyc}, 64'd0);
    step();
    check("clr.count.th.cycles", {32'd0, th_cyc}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
